// File: rtl/lycan_pkg.sv
// Shared definitions for the lycan USB-to-peripheral packet fabric.
// Holds the packet geometry, the default peripheral count and the arbiter FSM state types.
package lycan;

    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
    localparam int num_peripherals      = 8;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FETCH,
        D_DISPATCH
    } arb_down_state_t;

    typedef enum logic [1:0] {
        U_SCAN,
        U_FETCH,
        U_SEND
    } arb_up_state_t;

    // The peripheral address lives in the top bits of every packet.
    function automatic logic [periph_address_width-1:0] packet_addr(
        input logic [usb_packet_width-1:0] pkt
    );
        return pkt[usb_packet_width-1 -: periph_address_width];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder.
// Searches req upward from ptr with wrap-around and reports the first set index.
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    // cand[k] is the index visited k steps after ptr; hit[k] says it is requesting.
    logic [N-1:0][IW-1:0] cand;
    logic [N-1:0]         hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum         = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi]    = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
        assign hit[gi]     = req[cand[gi]];
    end

    // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[i];
            end
        end
    end

endmodule

// File: rtl/periph_arbiter.sv
// Central packet router between the USB FIFO interface and the peripherals.
// Downstream: pop host packets, decode the address field, write the addressed TX FIFO.
// Upstream: round-robin drain of peripheral RX FIFOs into the host-bound FIFO.
// Optional macro PERIPH_ARBITER_DROP_COUNT_EN adds a saturating drop_count output.
module periph_arbiter
    import lycan::*;
#(
    parameter int NUM_PERIPHS = num_peripherals
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [usb_packet_width-1:0]                host_rx_data,
    input  logic                                       host_rx_empty,
    output logic                                       host_rx_read,
    output logic [usb_packet_width-1:0]                periph_tx_data,
    output logic [NUM_PERIPHS-1:0]                     periph_tx_valid,
    input  logic [NUM_PERIPHS-1:0]                     periph_tx_full,
    input  logic [NUM_PERIPHS-1:0][usb_packet_width-1:0] periph_rx_data,
    output logic [NUM_PERIPHS-1:0]                     periph_rx_read,
    input  logic [NUM_PERIPHS-1:0]                     periph_rx_empty,
    output logic [usb_packet_width-1:0]                host_tx_data,
    output logic                                       host_tx_valid,
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
    output logic [15:0]                                drop_count,
`endif
    input  logic                                       host_tx_full
);

    localparam int AW        = periph_address_width;
    localparam int ADDR_SPAN = 1 << periph_address_width;
    localparam int IW        = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1;

    // ------------------------------------------------------------------
    // Downstream path
    // ------------------------------------------------------------------
    arb_down_state_t              down_state_reg;
    logic [usb_packet_width-1:0]  down_hold_reg;
    logic                         host_rx_read_reg;
    logic [NUM_PERIPHS-1:0]       periph_tx_valid_reg;

    logic [AW-1:0]                down_addr;
    logic                         down_addr_valid;
    logic [ADDR_SPAN-1:0]         full_ext;
    logic [NUM_PERIPHS-1:0]       down_onehot;

    assign down_addr       = packet_addr(down_hold_reg);
    assign down_addr_valid = ({1'b0, down_addr} < (AW+1)'(NUM_PERIPHS));

    // Pad the full vector to the whole address space so the index never leaves range;
    // padded slots are never consulted because invalid addresses are dropped first.
    for (genvar gi = 0; gi < ADDR_SPAN; gi++) begin : g_full_ext
        if (gi < NUM_PERIPHS) begin : g_real
            assign full_ext[gi] = periph_tx_full[gi];
        end else begin : g_pad
            assign full_ext[gi] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_PERIPHS; gi++) begin : g_down_dec
        assign down_onehot[gi] = (down_addr == AW'(gi));
    end

    // Downstream FSM: pop, capture, then dispatch or drop; stalls only on a full target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_state_reg      <= D_IDLE;
            down_hold_reg       <= '0;
            host_rx_read_reg    <= 1'b0;
            periph_tx_valid_reg <= '0;
        end else begin
            host_rx_read_reg    <= 1'b0;
            periph_tx_valid_reg <= '0;
            case (down_state_reg)
                D_IDLE: begin
                    if (!host_rx_empty) begin
                        host_rx_read_reg <= 1'b1;
                        down_state_reg   <= D_FETCH;
                    end
                end
                D_FETCH: begin
                    down_hold_reg  <= host_rx_data;
                    down_state_reg <= D_DISPATCH;
                end
                D_DISPATCH: begin
                    if (!down_addr_valid) begin
                        down_state_reg <= D_IDLE;
                    end else if (!full_ext[down_addr]) begin
                        periph_tx_valid_reg <= down_onehot;
                        down_state_reg      <= D_IDLE;
                    end
                end
                default: down_state_reg <= D_IDLE;
            endcase
        end
    end

    assign host_rx_read    = host_rx_read_reg;
    assign periph_tx_valid = periph_tx_valid_reg;
    assign periph_tx_data  = down_hold_reg;

`ifdef PERIPH_ARBITER_DROP_COUNT_EN
    logic [15:0] drop_count_reg;

    // Count packets discarded for an out-of-range address, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count_reg <= '0;
        end else if ((down_state_reg == D_DISPATCH) && !down_addr_valid &&
                     (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

    // ------------------------------------------------------------------
    // Upstream path
    // ------------------------------------------------------------------
    arb_up_state_t                up_state_reg;
    logic [IW-1:0]                ptr_reg;
    logic [IW-1:0]                sel_reg;
    logic [usb_packet_width-1:0]  up_hold_reg;
    logic [NUM_PERIPHS-1:0]       periph_rx_read_reg;
    logic                         host_tx_valid_reg;

    logic                         grant_valid;
    logic [IW-1:0]                grant_idx;
    logic [NUM_PERIPHS-1:0]       grant_onehot;

    rr_picker #(
        .N  (NUM_PERIPHS),
        .IW (IW)
    ) u_rr_picker (
        .req         (~periph_rx_empty),
        .ptr         (ptr_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    for (genvar gi = 0; gi < NUM_PERIPHS; gi++) begin : g_up_dec
        assign grant_onehot[gi] = (grant_idx == IW'(gi));
    end

    // Upstream FSM: pick a peripheral, capture its packet, forward it when the host has room.
    // The pointer moves past the served peripheral only once its packet is actually sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_state_reg       <= U_SCAN;
            ptr_reg            <= '0;
            sel_reg            <= '0;
            up_hold_reg        <= '0;
            periph_rx_read_reg <= '0;
            host_tx_valid_reg  <= 1'b0;
        end else begin
            periph_rx_read_reg <= '0;
            host_tx_valid_reg  <= 1'b0;
            case (up_state_reg)
                U_SCAN: begin
                    if (grant_valid) begin
                        periph_rx_read_reg <= grant_onehot;
                        sel_reg            <= grant_idx;
                        up_state_reg       <= U_FETCH;
                    end
                end
                U_FETCH: begin
                    up_hold_reg  <= periph_rx_data[sel_reg];
                    up_state_reg <= U_SEND;
                end
                U_SEND: begin
                    if (!host_tx_full) begin
                        host_tx_valid_reg <= 1'b1;
                        ptr_reg           <= (sel_reg == IW'(NUM_PERIPHS - 1)) ? '0
                                                                                : sel_reg + IW'(1);
                        up_state_reg      <= U_SCAN;
                    end
                end
                default: up_state_reg <= U_SCAN;
            endcase
        end
    end

    assign periph_rx_read = periph_rx_read_reg;
    assign host_tx_valid  = host_tx_valid_reg;
    assign host_tx_data   = up_hold_reg;

endmodule

// File: tb/tb_periph_arbiter.sv
// Scoreboard bench for periph_arbiter with 4 peripherals and show-ahead FIFO models.
module tb_periph_arbiter;
    import lycan::*;

    localparam int N = 4;
    localparam int W = usb_packet_width;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [W-1:0]         host_rx_data;
    logic                 host_rx_empty;
    logic                 host_rx_read;
    logic [W-1:0]         periph_tx_data;
    logic [N-1:0]         periph_tx_valid;
    logic [N-1:0]         periph_tx_full = '0;
    logic [N-1:0][W-1:0]  periph_rx_data;
    logic [N-1:0]         periph_rx_read;
    logic [N-1:0]         periph_rx_empty;
    logic [W-1:0]         host_tx_data;
    logic                 host_tx_valid;
    logic                 host_tx_full = 1'b0;
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
    logic [15:0]          drop_count;
`endif

    always #5 clk = ~clk;

    periph_arbiter #(.NUM_PERIPHS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .host_rx_data    (host_rx_data),
        .host_rx_empty   (host_rx_empty),
        .host_rx_read    (host_rx_read),
        .periph_tx_data  (periph_tx_data),
        .periph_tx_valid (periph_tx_valid),
        .periph_tx_full  (periph_tx_full),
        .periph_rx_data  (periph_rx_data),
        .periph_rx_read  (periph_rx_read),
        .periph_rx_empty (periph_rx_empty),
        .host_tx_data    (host_tx_data),
        .host_tx_valid   (host_tx_valid),
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
        .drop_count      (drop_count),
`endif
        .host_tx_full    (host_tx_full)
    );

    // ---------------- counters and scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int host_reads = 0;
    int rx_reads = 0;
    int tx_strobes = 0;
    int up_strobes = 0;
    logic [15:0] exp_drops = '0;

    typedef struct {
        int         port;
        logic [W-1:0] data;
    } dn_entry_t;

    dn_entry_t    down_exp[$];
    logic [W-1:0] up_exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- host downstream FIFO model (show-ahead) ----------------
    logic [W-1:0] host_mem [256];
    logic [7:0]   host_wr = '0;
    logic [7:0]   host_rd = '0;

    assign host_rx_data  = host_mem[host_rd];
    assign host_rx_empty = (host_rd == host_wr);

    always @(posedge clk) begin
        if (!rst)              host_rd <= host_wr;
        else if (host_rx_read) host_rd <= host_rd + 8'd1;
    end

    // ---------------- peripheral RX FIFO models (show-ahead) ----------------
    logic [W-1:0] pmem [N][64];
    logic [5:0]   pwr [N];
    logic [5:0]   prd [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            pwr[i] = '0;
            prd[i] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            periph_rx_data[i]  = pmem[i][prd[i]];
            periph_rx_empty[i] = (prd[i] == pwr[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst)                   prd[i] <= pwr[i];
            else if (periph_rx_read[i]) prd[i] <= prd[i] + 6'd1;
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] pm_q [N][$];
    int           model_ptr = 0;

    task automatic push_host(input logic [W-1:0] d);
        dn_entry_t e;
        int a;
        host_mem[host_wr] = d;
        host_wr = host_wr + 8'd1;
        a = int'(d[W-1 -: periph_address_width]);
        if (a < N) begin
            e.port = a;
            e.data = d;
            down_exp.push_back(e);
        end else if (exp_drops != 16'hFFFF) begin
            exp_drops = exp_drops + 16'd1;
        end
    endtask

    task automatic load_periph(input int port, input logic [W-1:0] d);
        pmem[port][pwr[port]] = d;
        pwr[port] = pwr[port] + 6'd1;
        pm_q[port].push_back(d);
    endtask

    // Round-robin at packet level: serve first non-empty port at or after the pointer,
    // then the pointer moves just past it.
    task automatic run_up_model();
        bit found = 1;
        while (found) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (model_ptr + k) % N;
                if (!found && pm_q[p].size() != 0) begin
                    found = 1;
                    up_exp.push_back(pm_q[p].pop_front());
                    model_ptr = (p + 1) % N;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (host_rx_read) host_reads++;
            if (periph_rx_read != '0) begin
                rx_reads++;
                check("rx_read_onehot", 64'($onehot(periph_rx_read)), 64'd1);
            end
            if (periph_tx_valid != '0) begin
                dn_entry_t e;
                logic [N-1:0] want_v;
                tx_strobes++;
                if (down_exp.size() == 0) begin
                    check("down_unexpected", 64'(periph_tx_valid), 64'd0);
                end else begin
                    e = down_exp.pop_front();
                    want_v = N'(1) << e.port;
                    $display("DN port_vec=%b data=%h exp_port=%0d", periph_tx_valid, periph_tx_data, e.port);
                    check("down_port", 64'(periph_tx_valid), 64'(want_v));
                    check("down_data", 64'(periph_tx_data), 64'(e.data));
                end
            end
            if (host_tx_valid) begin
                logic [W-1:0] d;
                up_strobes++;
                if (up_exp.size() == 0) begin
                    check("up_unexpected", 64'(host_tx_data), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    d = up_exp.pop_front();
                    $display("UP data=%h exp=%h", host_tx_data, d);
                    check("up_data", 64'(host_tx_data), 64'(d));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_down_drain(input string name);
        int n = 0;
        while ((down_exp.size() != 0 || !host_rx_empty) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(name, 64'(down_exp.size()), 64'd0);
    endtask

    task automatic wait_up_drain(input string name, input bit toggle_full);
        int n = 0;
        while (up_exp.size() != 0 && n < 1000) begin
            @(negedge clk);
            if (toggle_full) host_tx_full = ($urandom_range(0, 3) == 0);
            n++;
        end
        host_tx_full = 1'b0;
        repeat (4) @(negedge clk);
        check(name, 64'(up_exp.size()), 64'd0);
    endtask

    task automatic purge_model();
        down_exp.delete();
        up_exp.delete();
        for (int i = 0; i < N; i++) pm_q[i].delete();
        model_ptr = 0;
        exp_drops = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int t_rd;
        int r0;
        int s0;
        int u0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_host_rx_read", 64'(host_rx_read), 64'd0);
        check("rst_tx_valid", 64'(periph_tx_valid), 64'd0);
        check("rst_rx_read", 64'(periph_rx_read), 64'd0);
        check("rst_host_tx_valid", 64'(host_tx_valid), 64'd0);
        check("rst_tx_data", 64'(periph_tx_data), 64'd0);
        check("rst_host_tx_data", 64'(host_tx_data), 64'd0);
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
        check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single packet to peripheral 2, with latency measurement
        push_host(32'h4000_00AA);
        n = 0;
        while (!host_rx_read && n < 20) begin @(negedge clk); n++; end
        t_rd = cyc;
        n = 0;
        while (periph_tx_valid == '0 && n < 20) begin @(negedge clk); n++; end
        check("down_latency", 64'(cyc - t_rd), 64'd2);
        wait_down_drain("down_single_drain");

        // Invalid address is dropped
        s0 = tx_strobes;
        push_host(32'hE000_0001);
        wait_down_drain("drop_drain");
        check("drop_no_strobe", 64'(tx_strobes - s0), 64'd0);
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
        check("drop_count", 64'(drop_count), 64'(exp_drops));
`endif

        // Stall on full target; next host word must not be popped
        periph_tx_full = 4'b0010;
        r0 = host_reads;
        s0 = tx_strobes;
        push_host(32'h2000_0005);
        push_host(32'h0000_0011);
        repeat (12) @(negedge clk);
        check("stall_reads", 64'(host_reads - r0), 64'd1);
        check("stall_no_strobe", 64'(tx_strobes - s0), 64'd0);
        periph_tx_full = '0;
        wait_down_drain("stall_drain");
        check("stall_strobes", 64'(tx_strobes - s0), 64'd2);

        // Round-robin order 0,1,3,0,1,3 with upstream latency
        load_periph(0, 32'h0000_0A00); load_periph(0, 32'h0000_0A01);
        load_periph(1, 32'h2000_0B00); load_periph(1, 32'h2000_0B01);
        load_periph(3, 32'h6000_0D00); load_periph(3, 32'h6000_0D01);
        run_up_model();
        n = 0;
        while (periph_rx_read == '0 && n < 20) begin @(negedge clk); n++; end
        t_rd = cyc;
        n = 0;
        while (!host_tx_valid && n < 20) begin @(negedge clk); n++; end
        check("up_latency", 64'(cyc - t_rd), 64'd2);
        wait_up_drain("rr_drain", 1'b0);

        // Host upstream FIFO full while a packet waits in the send stage
        host_tx_full = 1'b1;
        r0 = rx_reads;
        u0 = up_strobes;
        load_periph(2, 32'h4000_0C00);
        load_periph(0, 32'h0000_0A10);
        run_up_model();
        repeat (12) @(negedge clk);
        check("hfull_rx_reads", 64'(rx_reads - r0), 64'd1);
        check("hfull_no_valid", 64'(up_strobes - u0), 64'd0);
        host_tx_full = 1'b0;
        wait_up_drain("hfull_drain", 1'b0);
        check("hfull_delivered", 64'(up_strobes - u0), 64'd2);

        // Randomised concurrent traffic in both directions
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    push_host({3'($urandom_range(0, 7)), 29'($urandom)});
                    repeat ($urandom_range(0, 4)) begin
                        @(negedge clk);
                        periph_tx_full = 4'($urandom) & 4'($urandom);
                    end
                end
                periph_tx_full = '0;
                wait_down_drain("rand_down_drain");
            end
            begin
                for (int b = 0; b < 6; b++) begin
                    for (int p = 0; p < N; p++) begin
                        int cnt;
                        cnt = $urandom_range(0, 3);
                        for (int c = 0; c < cnt; c++)
                            load_periph(p, {3'(p), 29'($urandom)});
                    end
                    run_up_model();
                    wait_up_drain("rand_up_drain", 1'b1);
                end
            end
        join
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
        check("rand_drop_count", 64'(drop_count), 64'(exp_drops));
`endif

        // Force a known non-zero pointer: serve peripheral 2 alone
        load_periph(2, 32'h4000_0C20);
        run_up_model();
        wait_up_drain("ptr_setup_drain", 1'b0);

        // Reset while stalled in dispatch (downstream) and send (upstream)
        periph_tx_full = 4'b1000;
        host_tx_full = 1'b1;
        push_host(32'h6000_0077);
        load_periph(1, 32'h2000_1234);
        run_up_model();
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_host_rx_read", 64'(host_rx_read), 64'd0);
        check("arst_tx_valid", 64'(periph_tx_valid), 64'd0);
        check("arst_tx_data", 64'(periph_tx_data), 64'd0);
        check("arst_rx_read", 64'(periph_rx_read), 64'd0);
        check("arst_host_tx_valid", 64'(host_tx_valid), 64'd0);
        check("arst_host_tx_data", 64'(host_tx_data), 64'd0);
`ifdef PERIPH_ARBITER_DROP_COUNT_EN
        check("arst_drop_count", 64'(drop_count), 64'd0);
`endif
        purge_model();
        periph_tx_full = '0;
        host_tx_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pointer back at 0: peripheral 0 must be served before 3
        load_periph(3, 32'h6000_0E00);
        load_periph(0, 32'h0000_0E01);
        run_up_model();
        wait_up_drain("post_rst_drain", 1'b0);

        // Post-reset downstream still works
        push_host(32'h2000_0F0F);
        wait_down_drain("post_rst_down_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
